pong_ball_motion: RTL
=====================

# pong_ball_motion

Ball-motion engine for the Pong datapath. Once per video frame it advances the ball position, bounces off the top and bottom walls and both paddles, and detects misses. It reports which side scored and re-centres the ball. It sits directly upstream of the pixel area-check stage, which consumes `ball_x`/`ball_y` against the VGA `row`/`col` to draw the ball.

## Interface
Parameters:
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `BALL_SIZE`, 4: ball edge length (square).
- `PADDLE_W`, 4: paddle width.
- `PADDLE_H`, 48: paddle height.
- `LEFT_PAD_X`, 60: left paddle left edge.
- `RIGHT_PAD_X`, 576: right paddle left edge.
- `SERVE_DELAY`, 60: number of frame ticks between serve and motion.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, synchronous to `clk`.
- `serve` in 1: level or pulse; starts a rally from IDLE.
- `speed` in 4: pixels per frame per axis; sampled at serve.
- `left_pad_y` in 10: left paddle top edge.
- `right_pad_y` in 10: right paddle top edge.
- `ball_x` out 10: ball left edge.
- `ball_y` out 10: ball top edge.
- `busy` out 1: high in SERVE_WAIT and MOVE.
- `score_left` out 1: one-cycle pulse; the right player missed.
- `score_right` out 1: one-cycle pulse; the left player missed.

## Operation
**Reset values**
- `ball_x` = (SCREEN_W−BALL_SIZE)/2 = 318; `ball_y` = (SCREEN_H−BALL_SIZE)/2 = 238.
- dir_right = 1, dir_down = 1.
- `busy`, `score_left`, `score_right` = 0; state = IDLE.

**States**
- **IDLE:** ball held at centre. `serve`=1 latches spd = (`speed`==0 ? 1 : `speed`), clears the delay counter, and goes to SERVE_WAIT.
- **SERVE_WAIT:** each `frame_tick` increments the delay counter. On the tick that makes count == SERVE_DELAY, go to MOVE; the position does not move on that tick.
- **MOVE:** each `frame_tick` applies one step, then the X rules below.
  - Step: nx = x ± spd, ny = y ± spd. Compute in 11 bits so underflow is detectable.
- **SCORED:** one cycle long; the score pulse is asserted here. Ball re-centres, dir_right points toward the player who conceded, dir_down = 1. Next state is IDLE.

**Vertical rules**
- Moving up with y < spd: y = 0, dir_down = 1.
- Moving down with y + spd ≥ SCREEN_H−BALL_SIZE: y = SCREEN_H−BALL_SIZE, dir_down = 0.

**Left paddle**
- Applies when moving left, x ≥ LEFT_PAD_X+PADDLE_W, nx ≤ LEFT_PAD_X+PADDLE_W, and the ball vertically overlaps the paddle.
- Overlap: y+BALL_SIZE > left_pad_y and y < left_pad_y+PADDLE_H, using the pre-step y.
- Result: x = LEFT_PAD_X+PADDLE_W, dir_right = 1.

**Right paddle**
- Applies when moving right, x+BALL_SIZE ≤ RIGHT_PAD_X, nx+BALL_SIZE ≥ RIGHT_PAD_X, and the ball vertically overlaps the paddle.
- Result: x = RIGHT_PAD_X−BALL_SIZE, dir_right = 0.

**Misses**
- Moving left with x < spd and no paddle hit: x = 0, go to SCORED with `score_right`.
- Moving right with x+spd > SCREEN_W−BALL_SIZE and no paddle hit: go to SCORED with `score_left`.

**Boundary and simultaneous events**
- A wall bounce and a paddle hit in the same step are both applied.
- A paddle hit takes precedence over a miss.
- `serve` is ignored outside IDLE.
- `frame_tick` is ignored in IDLE and SCORED.
- Paddle inputs are sampled only on the `frame_tick` cycle.

## Timing
- All outputs are registered.
- Position updates are visible one cycle after the `frame_tick` cycle.
- A score pulse appears one cycle after the tick that detected the miss and lasts exactly one cycle. The centred position appears in the same cycle as the pulse.
- `busy` rises one cycle after `serve` is accepted and falls in the SCORED cycle.
- `reset_n` low at any time, including mid-MOVE, forces the reset values immediately (asynchronously). Release is synchronous to `clk`.

## Configuration
- `BALL_SPEEDUP_EN` defined: each paddle hit sets spd = spd+1, saturating at 15. spd reloads from `speed` at the next serve.
- Not defined: spd is constant for the whole rally.

## Structure
- Package `pong_pkg` holds:
  - the `ball_state_t` enum {IDLE, SERVE_WAIT, MOVE, SCORED};
  - screen, ball and paddle default constants;
  - a 10-bit `coord_t` typedef.
- One natural sub-module: `serve_timer`, the frame-tick-counted delay with start/done.

## Test plan
- Reset → `ball_x`=318, `ball_y`=238, `busy`=0, no score pulses.
- SERVE_DELAY=2, `speed`=3, `serve` pulse, then 3 ticks → MOVE entered on tick 2; after tick 3 `ball_x`=321, `ball_y`=241.
- `speed`=0 served → step of 1 per tick.
- Ball moving up at y=2 with spd=3 → y=0; next tick y=3.
- `left_pad_y`=200, ball at x=66, y=220, moving left, spd=4 → x=64, moves right on the next tick (`BALL_SPEEDUP_EN`: spd becomes 5).
- `right_pad_y`=0, ball y=300 moving right past x=636 → `score_left` for exactly 1 cycle, ball at 318/238, IDLE, next serve goes right.
- `reset_n` low mid-MOVE → immediate re-centre and IDLE.
- `serve` held during MOVE → no effect.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong ball-motion engine.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_WAIT = 2'd1,
      MOVE       = 2'd2,
      SCORED     = 2'd3
   } ball_state_t;

   typedef logic [9:0] coord_t;

   localparam int SCREEN_W_DFLT    = 640;
   localparam int SCREEN_H_DFLT    = 480;
   localparam int BALL_SIZE_DFLT   = 4;
   localparam int PADDLE_W_DFLT    = 4;
   localparam int PADDLE_H_DFLT    = 48;
   localparam int LEFT_PAD_X_DFLT  = 60;
   localparam int RIGHT_PAD_X_DFLT = 576;
   localparam int SERVE_DELAY_DFLT = 60;

   // Speed increment that sticks at the 4-bit maximum.
   function automatic logic [3:0] spd_sat_inc(input logic [3:0] s);
      if (s == 4'd15) begin
         spd_sat_inc = 4'd15;
      end else begin
         spd_sat_inc = s + 4'd1;
      end
   endfunction

endpackage

// File: rtl/pong_ball_motion_serve_timer.sv
// Frame-tick counted serve delay: start clears the count, done flags the tick reaching DELAY.
module serve_timer #(
   parameter int DELAY = 60
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start_i,
   input  logic tick_i,
   output logic done_o
);

   localparam int CW = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
   localparam logic [CW-1:0] LAST = CW'(DELAY);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_inc_s;

   assign count_inc_s = count_q + CW'(1);
   assign done_o      = tick_i && (count_inc_s >= LAST);

   // Tick counter, restarted by each serve.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (start_i) begin
         count_q <= '0;
      end else if (tick_i) begin
         count_q <= count_inc_s;
      end else begin
         count_q <= count_q;
      end
   end

endmodule

// File: rtl/pong_ball_motion.sv
// Per-frame ball motion with wall/paddle bounces, miss detection and serve sequencing.
// Optional BALL_SPEEDUP_EN: every paddle hit bumps the speed by one, saturating at 15.
module pong_ball_motion
   import pong_pkg::*;
#(
   parameter int SCREEN_W    = SCREEN_W_DFLT,
   parameter int SCREEN_H    = SCREEN_H_DFLT,
   parameter int BALL_SIZE   = BALL_SIZE_DFLT,
   parameter int PADDLE_W    = PADDLE_W_DFLT,
   parameter int PADDLE_H    = PADDLE_H_DFLT,
   parameter int LEFT_PAD_X  = LEFT_PAD_X_DFLT,
   parameter int RIGHT_PAD_X = RIGHT_PAD_X_DFLT,
   parameter int SERVE_DELAY = SERVE_DELAY_DFLT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       serve,
   input  logic [3:0] speed,
   input  logic [9:0] left_pad_y,
   input  logic [9:0] right_pad_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       busy,
   output logic       score_left,
   output logic       score_right
);

   localparam logic [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
   localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
   localparam logic [10:0] BSZ    = 11'(BALL_SIZE);
   localparam logic [10:0] PAD_H  = 11'(PADDLE_H);
   localparam logic [10:0] L_FACE = 11'(LEFT_PAD_X + PADDLE_W);
   localparam logic [10:0] R_FACE = 11'(RIGHT_PAD_X);
   localparam coord_t X_CTR  = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam coord_t Y_CTR  = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam coord_t Y_BOT  = 10'(SCREEN_H - BALL_SIZE);
   localparam coord_t L_STOP = 10'(LEFT_PAD_X + PADDLE_W);
   localparam coord_t R_STOP = 10'(RIGHT_PAD_X - BALL_SIZE);

   ball_state_t state_q, state_d;
   coord_t      x_q, x_d, y_q, y_d;
   logic        dir_right_q, dir_right_d, dir_down_q, dir_down_d;
   logic [3:0]  spd_q, spd_d;
   logic        busy_q, busy_d;
   logic        score_left_q, score_left_d, score_right_q, score_right_d;

   logic        timer_start_s, timer_tick_s, timer_done_s;
   logic [10:0] x11_s, y11_s, spd11_s, lpy11_s, rpy11_s, nx_s, ny_dn_s;
   logic        overlap_l_s, overlap_r_s, left_hit_s, right_hit_s, miss_left_s, miss_right_s;

   serve_timer #(.DELAY(SERVE_DELAY)) u_serve_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (timer_start_s),
      .tick_i  (timer_tick_s),
      .done_o  (timer_done_s)
   );

   // 11-bit arithmetic so a step past zero shows up as a large value rather than wrapping into range.
   assign x11_s   = {1'b0, x_q};
   assign y11_s   = {1'b0, y_q};
   assign spd11_s = {7'd0, spd_q};
   assign lpy11_s = {1'b0, left_pad_y};
   assign rpy11_s = {1'b0, right_pad_y};
   assign nx_s    = dir_right_q ? (x11_s + spd11_s) : (x11_s - spd11_s);
   assign ny_dn_s = y11_s + spd11_s;

   assign overlap_l_s  = ((y11_s + BSZ) > lpy11_s) && (y11_s < (lpy11_s + PAD_H));
   assign overlap_r_s  = ((y11_s + BSZ) > rpy11_s) && (y11_s < (rpy11_s + PAD_H));
   assign left_hit_s   = !dir_right_q && (x11_s >= L_FACE) && (nx_s <= L_FACE) && overlap_l_s;
   assign right_hit_s  = dir_right_q && ((x11_s + BSZ) <= R_FACE) && ((nx_s + BSZ) >= R_FACE) && overlap_r_s;
   assign miss_left_s  = !dir_right_q && (x11_s < spd11_s) && !left_hit_s;
   assign miss_right_s = dir_right_q && ((x11_s + spd11_s) > X_MAX) && !right_hit_s;

   // Next-state, motion and scoring decisions.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      dir_right_d   = dir_right_q;
      dir_down_d    = dir_down_q;
      spd_d         = spd_q;
      busy_d        = busy_q;
      score_left_d  = 1'b0;
      score_right_d = 1'b0;
      timer_start_s = 1'b0;
      timer_tick_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (serve) begin
               spd_d         = (speed == 4'd0) ? 4'd1 : speed;
               timer_start_s = 1'b1;
               busy_d        = 1'b1;
               state_d       = SERVE_WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         SERVE_WAIT: begin
            timer_tick_s = frame_tick;
            if (timer_done_s) begin
               state_d = MOVE;
            end else begin
               state_d = SERVE_WAIT;
            end
         end
         MOVE: begin
            if (frame_tick) begin
               if (dir_down_q) begin
                  if (ny_dn_s >= Y_MAX) begin
                     y_d        = Y_BOT;
                     dir_down_d = 1'b0;
                  end else begin
                     y_d = ny_dn_s[9:0];
                  end
               end else if (y11_s < spd11_s) begin
                  y_d        = 10'd0;
                  dir_down_d = 1'b1;
               end else begin
                  y_d = y_q - {6'd0, spd_q};
               end

               if (left_hit_s || right_hit_s) begin
                  x_d         = left_hit_s ? L_STOP : R_STOP;
                  dir_right_d = left_hit_s;
`ifdef BALL_SPEEDUP_EN
                  spd_d = spd_sat_inc(spd_q);
`else
                  spd_d = spd_q;
`endif
               end else if (miss_left_s || miss_right_s) begin
                  // Re-centre now so the centred ball shows in the same cycle as the score pulse.
                  x_d           = X_CTR;
                  y_d           = Y_CTR;
                  dir_right_d   = miss_right_s;
                  dir_down_d    = 1'b1;
                  score_left_d  = miss_right_s;
                  score_right_d = miss_left_s;
                  busy_d        = 1'b0;
                  state_d       = SCORED;
               end else begin
                  x_d = nx_s[9:0];
               end
            end else begin
               state_d = MOVE;
            end
         end
         SCORED: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         x_q           <= X_CTR;
         y_q           <= Y_CTR;
         dir_right_q   <= 1'b1;
         dir_down_q    <= 1'b1;
         spd_q         <= 4'd1;
         busy_q        <= 1'b0;
         score_left_q  <= 1'b0;
         score_right_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         dir_right_q   <= dir_right_d;
         dir_down_q    <= dir_down_d;
         spd_q         <= spd_d;
         busy_q        <= busy_d;
         score_left_q  <= score_left_d;
         score_right_q <= score_right_d;
      end
   end

   assign ball_x      = x_q;
   assign ball_y      = y_q;
   assign busy        = busy_q;
   assign score_left  = score_left_q;
   assign score_right = score_right_q;

endmodule
